grid_bank_scheduler: RTL and testbench

GRID_BANK_SCHEDULER -- requirements
Module: grid_bank_scheduler

---
 rtl/grid_bank_scheduler.sv | 143 ++++++++++++++
 tb/tb_grid_bank_scheduler.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/grid_bank_scheduler.sv
// Ping-pong grid accumulator: read-modify-write into one bank while the other is read.
// Macro GRID_ACC_SAT_EN: words whose count is 255 refuse further samples.
module grid_bank_scheduler #(
  parameter int MAX_VALUE_ADDR = 80,
  parameter int GRID_SHIFT = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        zero_flag,
  input  logic        sample_valid,
  input  logic [15:0] sample_dist,
  input  logic [15:0] sample_gray,
  input  logic        seg_tick,
  input  logic        stat_busy,
  output logic        tannis_change,
  output logic        tannis1_acc_rden,
  output logic        tannis1_acc_wren,
  output logic [7:0]  tannis1_acc_addr,
  output logic [47:0] tannis1_acc_wrdata,
  input  logic [47:0] tannis1_acc_rddata,
  output logic        tannis2_acc_rden,
  output logic        tannis2_acc_wren,
  output logic [7:0]  tannis2_acc_addr,
  output logic [47:0] tannis2_acc_wrdata,
  input  logic [47:0] tannis2_acc_rddata,
  output logic        overrun,
  output logic [15:0] drop_cnt
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] SWAP  = 2'd3;

  logic [1:0]  state;
  logic        s1_v, s2_v, s3_v, wr_v, h1_v, h2_v;
  logic        s1_b, s2_b, s3_b, wr_b;
  logic [7:0]  s1_i, s2_i, s3_i, wr_i, h1_i, h2_i;
  logic [15:0] s1_g, s2_g, s3_g;
  logic [15:0] s1_d, s2_d, s3_d;
  logic [47:0] wr_d, h1_d, h2_d;

  logic [15:0] raw;
  logic [7:0]  idx;
  logic        accept, drop_in, pipe_empty;
  logic [47:0] rd, base, word;
  logic        sat_hit, sat_drop;
  logic [1:0]  drop_inc;
  logic [16:0] drop_sum;

  assign raw = sample_dist >> GRID_SHIFT;
  assign idx = (raw > 16'(MAX_VALUE_ADDR)) ? 8'(MAX_VALUE_ADDR) : raw[7:0];

  assign accept     = (state == ACCUM) && sample_valid;
  assign drop_in    = sample_valid && ((state == DRAIN) || (state == SWAP));
  assign pipe_empty = !(s1_v || s2_v || s3_v);

  // RAM data is stale for the three youngest results; youngest match wins
  always_comb begin
    rd = s3_b ? tannis2_acc_rddata : tannis1_acc_rddata;
    base = rd;
    if (h2_v && (h2_i == s3_i)) base = h2_d;
    if (h1_v && (h1_i == s3_i)) base = h1_d;
    if (wr_v && (wr_i == s3_i)) base = wr_d;
  end

`ifdef GRID_ACC_SAT_EN
  assign sat_hit = (base[31:24] == 8'hFF);
`else
  assign sat_hit = 1'b0;
`endif

  assign word = sat_hit ? base :
    {base[47:32] + s3_g, base[31:24] + 8'd1, base[23:0] + {8'd0, s3_d}};

  assign sat_drop = s3_v && sat_hit;
  assign drop_inc = {1'b0, drop_in} + {1'b0, sat_drop};
  assign drop_sum = {1'b0, drop_cnt} + {15'd0, drop_inc};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      tannis_change <= 1'b0;
      overrun <= 1'b0;
      drop_cnt <= '0;
      s1_v <= 1'b0; s2_v <= 1'b0; s3_v <= 1'b0;
      wr_v <= 1'b0; h1_v <= 1'b0; h2_v <= 1'b0;
      s1_b <= 1'b0; s2_b <= 1'b0; s3_b <= 1'b0; wr_b <= 1'b0;
      s1_i <= '0; s2_i <= '0; s3_i <= '0;
      wr_i <= '0; h1_i <= '0; h2_i <= '0;
      s1_g <= '0; s2_g <= '0; s3_g <= '0;
      s1_d <= '0; s2_d <= '0; s3_d <= '0;
      wr_d <= '0; h1_d <= '0; h2_d <= '0;
    end else begin
      overrun <= 1'b0;
      unique case (1'b1)
        (state == IDLE):  if (zero_flag) state <= ACCUM;
        (state == ACCUM): if (seg_tick) state <= DRAIN;
        (state == DRAIN): if (pipe_empty) state <= SWAP;
        (state == SWAP): begin
          state <= ACCUM;
          if (stat_busy) overrun <= 1'b1;
          else tannis_change <= ~tannis_change;
        end
      endcase

      s1_v <= accept;
      s1_b <= tannis_change;
      s1_i <= idx;
      s1_g <= sample_gray;
      s1_d <= sample_dist;
      s2_v <= s1_v; s2_b <= s1_b; s2_i <= s1_i;
      s2_g <= s1_g; s2_d <= s1_d;
      s3_v <= s2_v; s3_b <= s2_b; s3_i <= s2_i;
      s3_g <= s2_g; s3_d <= s2_d;

      wr_v <= s3_v;
      wr_b <= s3_b;
      wr_i <= s3_v ? s3_i : 8'd0;
      wr_d <= s3_v ? word : 48'd0;
      h1_v <= wr_v; h1_i <= wr_i; h1_d <= wr_d;
      h2_v <= h1_v; h2_i <= h1_i; h2_d <= h1_d;

      if (zero_flag) drop_cnt <= '0;
      else if (drop_sum[16]) drop_cnt <= 16'hFFFF;
      else drop_cnt <= drop_sum[15:0];
    end
  end

  assign tannis1_acc_rden = s1_v && !s1_b;
  assign tannis2_acc_rden = s1_v && s1_b;
  assign tannis1_acc_wren = wr_v && !wr_b;
  assign tannis2_acc_wren = wr_v && wr_b;

  assign tannis1_acc_addr = tannis1_acc_wren ? wr_i :
                            tannis1_acc_rden ? s1_i : 8'd0;
  assign tannis2_acc_addr = tannis2_acc_wren ? wr_i :
                            tannis2_acc_rden ? s1_i : 8'd0;

  assign tannis1_acc_wrdata = tannis1_acc_wren ? wr_d : 48'd0;
  assign tannis2_acc_wrdata = tannis2_acc_wren ? wr_d : 48'd0;

endmodule

// File: tb/tb_grid_bank_scheduler.sv
// Bench for grid_bank_scheduler: bank RAM models plus a sample-level reference.
// Outputs are compared every cycle; directed cases pin literal values.
module tb_grid_bank_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, zero_flag, sample_valid, seg_tick, stat_busy;
  logic [15:0] sample_dist, sample_gray;
  logic        tannis_change, overrun;
  logic [15:0] drop_cnt;
  logic        t1_rden, t1_wren, t2_rden, t2_wren;
  logic [7:0]  t1_addr, t2_addr;
  logic [47:0] t1_wd, t2_wd, t1_rd, t2_rd;

  grid_bank_scheduler dut (
    .clk(clk), .rst_n(rst_n), .zero_flag(zero_flag),
    .sample_valid(sample_valid), .sample_dist(sample_dist),
    .sample_gray(sample_gray), .seg_tick(seg_tick), .stat_busy(stat_busy),
    .tannis_change(tannis_change),
    .tannis1_acc_rden(t1_rden), .tannis1_acc_wren(t1_wren),
    .tannis1_acc_addr(t1_addr), .tannis1_acc_wrdata(t1_wd),
    .tannis1_acc_rddata(t1_rd),
    .tannis2_acc_rden(t2_rden), .tannis2_acc_wren(t2_wren),
    .tannis2_acc_addr(t2_addr), .tannis2_acc_wrdata(t2_wd),
    .tannis2_acc_rddata(t2_rd),
    .overrun(overrun), .drop_cnt(drop_cnt)
  );

  // Bank RAMs, two-cycle read latency
  logic [47:0] ram [2][256] = '{default: '0};
  logic [47:0] q1 [2] = '{default: '0};
  logic        pre_en = 1'b0;
  logic        pre_b = 1'b0;
  logic [7:0]  pre_a = '0;
  logic [47:0] pre_d = '0;

  always @(posedge clk) begin
    if (t1_wren) ram[0][t1_addr] <= t1_wd;
    if (t2_wren) ram[1][t2_addr] <= t2_wd;
    if (pre_en) ram[pre_b][pre_a] <= pre_d;
    if (t1_rden) q1[0] <= ram[0][t1_addr];
    if (t2_rden) q1[1] <= ram[1][t2_addr];
    t1_rd <= q1[0];
    t2_rd <= q1[1];
  end

  // Reference model state
  logic [47:0] mm [2][256];
  int          mode, swap_cyc, last_acc, cyc, drop_e;
  logic        tog, ov_e;
  logic        e_rv [8][2];
  logic [7:0]  e_ri [8][2];
  logic        e_wv [8][2];
  logic [7:0]  e_wi [8][2];
  logic [47:0] e_wd [8][2];
  int          sat_ring [8];
  logic        hist_v [8];
  logic [15:0] hist_d [8];
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] gidx(input logic [15:0] d);
    int r;
    r = int'(d) / 32;
    if (r > 80) r = 80;
    return 8'(r);
  endfunction

  task automatic clear_slot(input int s);
    for (int b = 0; b < 2; b++) begin
      e_rv[s][b] = 1'b0; e_ri[s][b] = '0;
      e_wv[s][b] = 1'b0; e_wi[s][b] = '0; e_wd[s][b] = '0;
    end
    sat_ring[s] = 0;
  endtask

  task automatic model_clear();
    for (int s = 0; s < 8; s++) clear_slot(s);
    mode = 0; tog = 1'b0; ov_e = 1'b0; drop_e = 0;
    last_acc = -100; swap_cyc = 0;
  endtask

  task automatic accept(input int k);
    int b;
    logic [7:0] i;
    logic [47:0] old, nw;
    logic sat;
    b = tog ? 1 : 0;
    i = gidx(sample_dist);
    old = mm[b][i];
    sat = 1'b0;
`ifdef GRID_ACC_SAT_EN
    sat = (old[31:24] == 8'hFF);
`endif
    nw = sat ? old : {old[47:32] + sample_gray, old[31:24] + 8'd1,
                      old[23:0] + {8'h00, sample_dist}};
    mm[b][i] = nw;
    e_rv[(k + 1) % 8][b] = 1'b1;
    e_ri[(k + 1) % 8][b] = i;
    e_wv[(k + 4) % 8][b] = 1'b1;
    e_wi[(k + 4) % 8][b] = i;
    e_wd[(k + 4) % 8][b] = nw;
    if (sat) sat_ring[(k + 3) % 8]++;
    last_acc = k;
  endtask

  // mode: 0 idle, 1 accumulating, 2 draining or swapping
  task automatic model_step(input int k);
    int dropped;
    dropped = 0;
    ov_e = 1'b0;
    if (mode == 0) begin
      if (zero_flag) mode = 1;
    end else if (mode == 1) begin
      if (sample_valid) accept(k);
      if (seg_tick) begin
        mode = 2;
        swap_cyc = (k + 2 > last_acc + 5) ? k + 2 : last_acc + 5;
      end
    end else begin
      if (sample_valid) dropped++;
      if (k == swap_cyc) begin
        if (stat_busy) ov_e = 1'b1;
        else tog = ~tog;
        mode = 1;
      end
    end
    dropped += sat_ring[k % 8];
    sat_ring[k % 8] = 0;
    if (zero_flag) drop_e = 0;
    else drop_e = (drop_e + dropped > 65535) ? 65535 : drop_e + dropped;
  endtask

  task automatic compare();
    int s;
    logic [7:0] ea [2];
    s = cyc % 8;
    for (int b = 0; b < 2; b++)
      ea[b] = e_wv[s][b] ? e_wi[s][b] : (e_rv[s][b] ? e_ri[s][b] : 8'd0);
    chk("bank1_rden", t1_rden, e_rv[s][0]);
    chk("bank2_rden", t2_rden, e_rv[s][1]);
    chk("bank1_wren", t1_wren, e_wv[s][0]);
    chk("bank2_wren", t2_wren, e_wv[s][1]);
    chk("bank1_addr", t1_addr, ea[0]);
    chk("bank2_addr", t2_addr, ea[1]);
    chk("bank1_wrdata", t1_wd, e_wv[s][0] ? e_wd[s][0] : 48'd0);
    chk("bank2_wrdata", t2_wd, e_wv[s][1] ? e_wd[s][1] : 48'd0);
    chk("tannis_change", tannis_change, tog);
    chk("overrun", overrun, ov_e);
    chk("drop_cnt", drop_cnt, 64'(drop_e));
    for (int b = 0; b < 2; b++) begin
      e_rv[s][b] = 1'b0; e_wv[s][b] = 1'b0;
    end
  endtask

  task automatic tick();
    hist_v[cyc % 8] = sample_valid;
    hist_d[cyc % 8] = sample_dist;
    @(posedge clk);
    if (rst_n) model_step(cyc);
    cyc++;
    @(negedge clk);
    compare();
    zero_flag = 1'b0;
    seg_tick = 1'b0;
    sample_valid = 1'b0;
    pre_en = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_clear();
    repeat (3) tick();
    rst_n = 1'b1;
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < 256; a++) mm[b][a] = ram[b][a];
  endtask

  task automatic send(input logic [15:0] d, input logic [15:0] g);
    sample_valid = 1'b1;
    sample_dist = d;
    sample_gray = g;
    tick();
  endtask

  initial begin
    int ov, w, bad;
    rst_n = 1'b0;
    zero_flag = 1'b0; sample_valid = 1'b0; seg_tick = 1'b0;
    stat_busy = 1'b0; sample_dist = '0; sample_gray = '0;
    cyc = 0;
    for (int s = 0; s < 8; s++) begin
      hist_v[s] = 1'b0; hist_d[s] = '0;
    end
    model_clear();
    do_reset();
    chk("reset_tannis_change", tannis_change, 0);
    chk("reset_drop_cnt", drop_cnt, 0);
    chk("reset_rden", {t1_rden, t2_rden}, 0);

    zero_flag = 1'b1;
    tick();
    send(16'd100, 16'd7);
    chk("first_rden", t1_rden, 1);
    chk("first_addr", t1_addr, 3);
    repeat (3) tick();
    chk("first_wren", t1_wren, 1);
    chk("first_wrdata", t1_wd, {16'd7, 8'd1, 24'd100});

    repeat (3) tick();
    for (int i = 0; i < 4; i++) send(16'd64, 16'd1);
    repeat (3) tick();
    chk("b2b_addr", t1_addr, 2);
    chk("b2b_word", t1_wd, {16'd4, 8'd4, 24'd256});

    repeat (4) tick();
    send(16'hFFFF, 16'd9);
    chk("clamp_addr", t1_addr, 80);

    repeat (6) tick();
    seg_tick = 1'b1;
    tick();
    send(16'd200, 16'd1);
    send(16'd200, 16'd1);
    chk("drain_drops", drop_cnt, 2);
    w = 0;
    while (!tannis_change && w < 6) begin
      tick();
      w++;
    end
    chk("swap_toggle", tannis_change, 1);

    stat_busy = 1'b1;
    repeat (2) tick();
    seg_tick = 1'b1;
    tick();
    ov = 0;
    repeat (8) begin
      if (overrun) ov++;
      tick();
    end
    chk("overrun_pulses", ov, 1);
    chk("overrun_no_toggle", tannis_change, 1);
    stat_busy = 1'b0;
    send(16'd160, 16'd2);
    chk("same_bank2_rden", t2_rden, 1);
    chk("same_bank1_idle", t1_rden, 0);

    repeat (6) tick();
    pre_en = 1'b1; pre_b = 1'b1; pre_a = 8'd10;
    pre_d = {16'h0005, 8'hFF, 24'h000010};
    mm[1][10] = pre_d;
    tick();
    send(16'd320, 16'd3);
    repeat (3) tick();
    chk("full_wren", t2_wren, 1);
`ifdef GRID_ACC_SAT_EN
    chk("full_word", t2_wd, {16'h0005, 8'hFF, 24'h000010});
    chk("full_drop", drop_cnt, 3);
`else
    chk("full_word", t2_wd, {16'h0008, 8'h00, 24'h000150});
    chk("full_drop", drop_cnt, 2);
`endif

    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) do_reset();
      zero_flag = ($urandom_range(0, 59) == 0);
      seg_tick = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 9) == 0) stat_busy = ~stat_busy;
      sample_valid = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0)
        sample_dist = 16'($urandom_range(2592, 65535));
      else
        sample_dist = 16'(($urandom_range(0, 4) << 5) | $urandom_range(0, 31));
      sample_gray = 16'($urandom);
      if (hist_v[(cyc + 5) % 8]) sample_dist = hist_d[(cyc + 5) % 8];
      tick();
    end

    stat_busy = 1'b0;
    repeat (10) tick();
    bad = 0;
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < 256; a++)
        if (ram[b][a] !== mm[b][a]) bad++;
    chk("ram_contents", bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
